mux_sweep_ctrl: RTL

- Hardware sequencer that exhaustively exercises the lab 2:1 select function unit, z = (c & b) | (a & ~c), across all 8 input combinations.
- Drives the vector onto the unit under test, waits a programmable settle time, samples z and compares it with an internal golden model.
- Accumulates pass/fail counts and the first failing vector, then reports completion through a start/done handshake.
- Sits between lab control logic (switches/LEDs or a bench) and the combinational gate-level unit.

---
 rtl/lab_pkg.sv | 20 ++
 rtl/mux_golden.sv | 11 +
 rtl/mux_sweep_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/lab_pkg.sv
// Shared definitions for the 2:1 select unit sweep: state encoding,
// vector geometry and the golden select function.
package lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    // z = (c & b) | (a & ~c) with vec = {a,b,c}, c in the LSB
    function automatic logic mux_expect(input logic [VEC_W-1:0] vec);
        return vec[0] ? vec[1] : vec[2];
    endfunction

endpackage

// File: rtl/mux_golden.sv
// Combinational reference model of the 2:1 select unit.
module mux_golden
    import lab_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_z
);

    assign exp_z = mux_expect(vec);

endmodule

// File: rtl/mux_sweep_ctrl.sv
// Walks all 8 input vectors through the external select unit, waits SETTLE
// cycles per vector, compares dut_z with the golden model and keeps
// pass/fail statistics plus the first failing vector.
module mux_sweep_ctrl
    import lab_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec_o,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       exp_z;
    logic       match;

    mux_golden u_golden (
        .vec   (vec_o),
        .exp_z (exp_z)
    );

    // Case equality so an X or Z from the unit counts as a mismatch
    assign match = (dut_z === exp_z);

    // Sweep sequencer; every output is registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            settle_cnt       <= '0;
            vec_o            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            all_pass         <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        pass_cnt         <= '0;
                        fail_cnt         <= '0;
                        all_pass         <= 1'b0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        vec_o            <= '0;
                        settle_cnt       <= '0;
                        busy             <= 1'b1;
                        state            <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        // result of this sample is dropped
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (match) begin
                            pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            fail_cnt <= fail_cnt + CNT_W'(1);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec_o;
                            end
                        end
                        if (vec_o == LAST_VEC) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            vec_o      <= vec_o + VEC_W'(1);
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    // fail_cnt already holds the last vector's result here
                    all_pass <= (fail_cnt == '0);
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
